// File: rtl/line_mirror_pp_pkg.sv
// Shared defaults for the horizontal line mirror: pixel format, line length
// and the input-valid to output-valid latency of the ping-pong buffer.
package line_mirror_pp_pkg;

    localparam int DEF_DATA_W   = 10;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_LINE_W   = 640;

    // One registered RAM read between a paced input valid and oDVAL.
    localparam int DVAL_LATENCY = 1;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

    function automatic bank_e other_bank(input bank_e bank);
        return (bank == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Simple dual-port line store: one write port, one registered read port, one clock.
// The read register is reset so the mirror output starts at zero.
module line_bank_ram #(
    parameter int WIDTH = 30,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Holds its value between reads, which gives oDATA its hold behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_mirror_pp.sv
// Ping-pong horizontal line mirror: each input line fills one bank while the
// previously completed bank is read out, optionally in reverse column order.
module line_mirror_pp
    import line_mirror_pp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int LINE_W   = DEF_LINE_W,
    localparam int ADDR_W  = $clog2(LINE_W),
    localparam int PIX_W   = CHANNELS * DATA_W
) (
    input  logic             iCCD_PIXCLK,
    input  logic             iRST_N,
    input  logic             iSOF,
    input  logic             iMIRROR,
    input  logic [PIX_W-1:0] iDATA,
    input  logic             iDVAL,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL,
    output logic             oDROP
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_W - 1);

    logic [ADDR_W-1:0] wr_col;
    logic [ADDR_W-1:0] rd_col;
    logic [ADDR_W-1:0] rd_addr_col;
    bank_e             wr_bank;
    bank_e             rd_bank;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic [1:0]        mode;

    logic pix_ok;
    logic wr_en;
    logic rd_en;
    logic drop;
    logic wr_last;
    logic rd_last;
    logic abandon;

    // A start-of-frame cycle swallows its pixel on both sides without flagging a drop.
    always_comb begin
        pix_ok      = iDVAL && !iSOF;
        wr_en       = pix_ok && !full[wr_bank];
        drop        = pix_ok && full[wr_bank];
        rd_en       = pix_ok && full[rd_bank];
        wr_last     = wr_en && (wr_col == LAST_COL);
        rd_last     = rd_en && (rd_col == LAST_COL);
        abandon     = iSOF && (rd_col != '0);
        rd_addr_col = mode[rd_bank] ? (LAST_COL - rd_col) : rd_col;
    end

    // Write and read always retire different banks, so both updates can land together.
    always_comb begin
        full_next = full;
        if (wr_last) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_last || abandon) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_col  <= '0;
            wr_bank <= BANK_A;
            mode    <= '0;
        end else if (iSOF) begin
            wr_col <= '0;
        end else if (wr_en) begin
            if (wr_last) begin
                wr_col        <= '0;
                wr_bank       <= other_bank(wr_bank);
                mode[wr_bank] <= iMIRROR;
            end else begin
                wr_col <= wr_col + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_col  <= '0;
            rd_bank <= BANK_A;
        end else if (rd_last || abandon) begin
            rd_col  <= '0;
            rd_bank <= other_bank(rd_bank);
        end else if (rd_en) begin
            rd_col <= rd_col + ADDR_W'(1);
        end
    end

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            full  <= '0;
            oDVAL <= 1'b0;
            oDROP <= 1'b0;
        end else begin
            full  <= full_next;
            oDVAL <= rd_en;
            oDROP <= drop;
        end
    end

    // Bank select is the address MSB, so the array spans 2*2**ADDR_W words.
    line_bank_ram #(
        .WIDTH (PIX_W),
        .AW    (ADDR_W + 1)
    ) u_ram (
        .clk     (iCCD_PIXCLK),
        .rst_n   (iRST_N),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_col}),
        .wr_data (iDATA),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank, rd_addr_col}),
        .rd_data (oDATA)
    );

endmodule

// File: tb/tb_line_mirror_pp.sv
// Scoreboard bench for line_mirror_pp: a queue-based line model predicts every
// output pixel, its cycle, and any drop; a monitor compares them as they appear.
module tb_line_mirror_pp;

    localparam int DATA_W   = 10;
    localparam int CHANNELS = 3;
    localparam int LINE_W   = 8;
    localparam int PIX_W    = DATA_W * CHANNELS;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sof    = 1'b0;
    logic             mirror = 1'b0;
    logic             dval   = 1'b0;
    logic [PIX_W-1:0] din    = '0;
    logic [PIX_W-1:0] dout;
    logic             dout_val;
    logic             drop;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    typedef struct packed {
        int unsigned      cyc;
        logic [PIX_W-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int unsigned      drop_q[$];
    logic [PIX_W-1:0] stored[$];
    logic [PIX_W-1:0] wr_line[$];
    int               pos = 0;
    logic [PIX_W-1:0] last_out = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    line_mirror_pp #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .LINE_W   (LINE_W)
    ) dut (
        .iCCD_PIXCLK (clk),
        .iRST_N      (rst_n),
        .iSOF        (sof),
        .iMIRROR     (mirror),
        .iDATA       (din),
        .iDVAL       (dval),
        .oDATA       (dout),
        .oDVAL       (dout_val),
        .oDROP       (drop)
    );

    task automatic checkOutput(input string name, input logic [PIX_W-1:0] got,
                               input logic [PIX_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic logic [PIX_W-1:0] colPixel(input int c);
        logic [DATA_W-1:0] v;
        v = DATA_W'(c);
        return {CHANNELS{v}};
    endfunction

    // Line-level model: stored holds the remaining output pixels of completed
    // lines already in emission order; pos is how far into the head line we are.
    task automatic modelStep(input logic s, input logic m, input logic v,
                             input logic [PIX_W-1:0] d, input int unsigned c);
        int lines;
        if (s) begin
            wr_line.delete();
            if (pos != 0) begin
                repeat (LINE_W - pos) void'(stored.pop_front());
                pos = 0;
            end
            return;
        end
        if (!v) return;
        lines = (stored.size() + pos) / LINE_W;
        if (lines > 0) begin
            exp_q.push_back('{cyc: c + 1, data: stored.pop_front()});
            pos = (pos + 1) % LINE_W;
        end
        if (lines < 2) begin
            wr_line.push_back(d);
            if (wr_line.size() == LINE_W) begin
                for (int i = 0; i < LINE_W; i++)
                    stored.push_back(m ? wr_line[LINE_W-1-i] : wr_line[i]);
                wr_line.delete();
            end
        end else begin
            drop_q.push_back(c + 1);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic m, input logic v,
                                 input logic [PIX_W-1:0] d);
        @(negedge clk);
        sof    = s;
        mirror = m;
        dval   = v;
        din    = d;
        modelStep(s, m, v, d, cyc);
    endtask

    task automatic sendLine(input logic mir_a, input logic mir_b, input int toggle_col,
                            input int gap, input int sof_col, input bit rnd);
        logic             m;
        logic [PIX_W-1:0] d;
        for (int c = 0; c < LINE_W; c++) begin
            m = (c < toggle_col) ? mir_a : mir_b;
            d = rnd ? PIX_W'({$urandom, $urandom}) : colPixel(c);
            if (c == sof_col) begin
                applyStimulus(1'b1, m, 1'b1, d);
                return;
            end
            applyStimulus(1'b0, m, 1'b1, d);
            repeat (gap) applyStimulus(1'b0, m, 1'b0, '0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        int unsigned dc;
        if (!rst_n) begin
            last_out = '0;
        end else begin
            if (dout_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_dval: got data %h at cycle %0d, want no output",
                             dout, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_cycle", PIX_W'(cyc), PIX_W'(e.cyc));
                    checkOutput("out_data", dout, e.data);
                    last_out = e.data;
                end
            end else begin
                checkOutput("hold_data", dout, last_out);
            end
            if (drop) begin
                if (drop_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_drop: got oDROP=1 at cycle %0d, want 0", cyc);
                end else begin
                    dc = drop_q.pop_front();
                    checkOutput("drop_cycle", PIX_W'(cyc), PIX_W'(dc));
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_dval: got no output at cycle %0d, want data %h",
                         e.cyc, e.data);
            end
            while (drop_q.size() > 0 && drop_q[0] < cyc) begin
                dc = drop_q.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_drop: got oDROP=0 at cycle %0d, want 1", dc);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_data", dout, '0);
        checkOutput("reset_dval", PIX_W'(dout_val), '0);
        checkOutput("reset_drop", PIX_W'(drop), '0);
        #3 rst_n = 1'b1;

        // Mirrored pair, then straight pair: first line of the stream emits nothing.
        sendLine(1'b1, 1'b1, 0, 0, -1, 1'b0);
        sendLine(1'b1, 1'b1, 0, 0, -1, 1'b0);
        sendLine(1'b0, 1'b0, 0, 0, -1, 1'b0);
        sendLine(1'b0, 1'b0, 0, 0, -1, 1'b0);

        // Mirror request changes mid-line; only the value at the last column counts.
        sendLine(1'b1, 1'b0, 4, 0, -1, 1'b0);
        sendLine(1'b0, 1'b1, 4, 0, -1, 1'b0);
        sendLine(1'b0, 1'b0, 0, 0, -1, 1'b0);

        // Input gaps must reappear unchanged at the output.
        sendLine(1'b0, 1'b0, 0, 2, -1, 1'b0);
        sendLine(1'b1, 1'b1, 0, 2, -1, 1'b0);
        sendLine(1'b0, 1'b0, 0, 2, -1, 1'b1);

        // Start of frame in the middle of a line abandons the partial read.
        sendLine(1'b0, 1'b0, 0, 0, 3, 1'b0);
        sendLine(1'b1, 1'b1, 0, 0, -1, 1'b1);
        sendLine(1'b0, 1'b0, 0, 0, -1, 1'b1);
        sendLine(1'b0, 1'b0, 0, 0, -1, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 7, PIX_W'({$urandom, $urandom}));
        end

        // Re-align, store a line, then reset while the next line is streaming out.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        sendLine(1'b1, 1'b1, 0, 0, -1, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b1, colPixel(c + 1));
        @(posedge clk);
        #2;
        checkOutput("pre_reset_dval", PIX_W'(dout_val), PIX_W'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("midline_reset_dval", PIX_W'(dout_val), '0);
        checkOutput("midline_reset_data", dout, '0);
        checkOutput("midline_reset_drop", PIX_W'(drop), '0);
        exp_q.delete();
        drop_q.delete();
        stored.delete();
        wr_line.delete();
        pos  = 0;
        dval = 1'b0;
        sof  = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;

        sendLine(1'b1, 1'b1, 0, 0, -1, 1'b1);
        sendLine(1'b0, 1'b0, 0, 1, -1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0);

        checkOutput("pending_outputs", PIX_W'(exp_q.size()), '0);
        checkOutput("pending_drops", PIX_W'(drop_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
